// File: rtl/ongorucu_erisim_hakemi.sv
// Arbitrates the single gshare table port between fetch lookups and buffered execute updates.
// Fetch reads win; updates queue in an in-order FIFO that drains when the port is free or is forced to drain.
//
// state  | meaning
// BOSTA  | fetch has priority; FIFO head or bypass update uses idle port cycles
// BOSALT | forced drain; fetch stalled, one FIFO entry written per cycle
`timescale 1ns/1ps
module ongorucu_erisim_hakemi #(
  parameter int KUYRUK_DERINLIK = 4,
  parameter int MAKS_BEKLEME    = 8,
  parameter int PS_LEN          = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               getir_gecerli,
  input  logic [PS_LEN-1:0]                  getir_ps,
  output logic                               getir_hazir,
  input  logic                               yurut_gecerli,
  input  logic [PS_LEN-1:0]                  yurut_ps,
  input  logic                               yurut_dallan,
  input  logic [PS_LEN-1:0]                  yurut_dallan_ps,
  output logic                               yurut_hazir,
  output logic                               tablo_gecerli,
  output logic                               tablo_yaz,
  output logic [PS_LEN-1:0]                  tablo_ps,
  output logic                               tablo_dallan,
  output logic [PS_LEN-1:0]                  tablo_dallan_ps,
  input  logic                               tablo_sonuc_dallan,
  input  logic [PS_LEN-1:0]                  tablo_sonuc_dallan_ps,
  output logic                               sonuc_gecerli,
  output logic                               sonuc_dallan,
  output logic [PS_LEN-1:0]                  sonuc_dallan_ps,
  output logic [$clog2(KUYRUK_DERINLIK):0]   kuyruk_sayisi
);

  localparam int PTR_W = $clog2(KUYRUK_DERINLIK);
  localparam int CNT_W = PTR_W + 1;
  localparam int YAS_W = $clog2(MAKS_BEKLEME + 1);
  localparam logic [CNT_W-1:0] DOLU     = CNT_W'(KUYRUK_DERINLIK);
  localparam logic [YAS_W-1:0] YAS_MAKS = YAS_W'(MAKS_BEKLEME);

  typedef enum logic {BOSTA = 1'b0, BOSALT = 1'b1} durum_t;

  durum_t durum_q, durum_d;

  logic [PS_LEN-1:0] k_ps     [KUYRUK_DERINLIK];
  logic              k_dallan [KUYRUK_DERINLIK];
  logic [PS_LEN-1:0] k_hedef  [KUYRUK_DERINLIK];

  logic [PTR_W-1:0] oku_ptr_q, yaz_ptr_q;
  logic [CNT_W-1:0] sayi_q, sayi_d;
  logic [YAS_W-1:0] yas_q, yas_d;
  logic             sonuc_gecerli_q;

  logic bos;
  logic okuma, cekme, atlama, ekleme;

  assign bos         = (sayi_q == '0);
  assign yurut_hazir = !rst && (sayi_q < DOLU);

  // Port decision for this cycle; everything is suppressed while rst is high.
  always_comb begin
    okuma  = 1'b0;
    cekme  = 1'b0;
    atlama = 1'b0;
    ekleme = 1'b0;
    if (!rst) begin
      case (durum_q)
        BOSTA: begin
          if (getir_gecerli)      okuma  = 1'b1;
          else if (!bos)          cekme  = 1'b1;
          else if (yurut_gecerli) atlama = 1'b1;
        end
        BOSALT:  cekme = !bos;
        default: cekme = 1'b0;
      endcase
      ekleme = yurut_gecerli && yurut_hazir && !atlama;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q         <= BOSTA;
      sayi_q          <= '0;
      yas_q           <= '0;
      oku_ptr_q       <= '0;
      yaz_ptr_q       <= '0;
      sonuc_gecerli_q <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      sayi_q          <= sayi_d;
      yas_q           <= yas_d;
      sonuc_gecerli_q <= okuma;
      if (ekleme) yaz_ptr_q <= yaz_ptr_q + PTR_W'(1);
      if (cekme)  oku_ptr_q <= oku_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ekleme) begin
      k_ps[yaz_ptr_q]     <= yurut_ps;
      k_dallan[yaz_ptr_q] <= yurut_dallan;
      k_hedef[yaz_ptr_q]  <= yurut_dallan_ps;
    end
  end

  // Transitions look at next-cycle occupancy and age.
  always_comb begin
    sayi_d = sayi_q;
    if (ekleme && !cekme)      sayi_d = sayi_q + CNT_W'(1);
    else if (cekme && !ekleme) sayi_d = sayi_q - CNT_W'(1);

    if (cekme || bos)          yas_d = '0;
    else if (yas_q != YAS_MAKS) yas_d = yas_q + YAS_W'(1);
    else                       yas_d = yas_q;

    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (sayi_d == DOLU || yas_d == YAS_MAKS) durum_d = BOSALT;
      BOSALT:  if (sayi_d == '0) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    getir_hazir     = !rst && (durum_q == BOSTA);
    tablo_gecerli   = 1'b0;
    tablo_yaz       = 1'b0;
    tablo_ps        = '0;
    tablo_dallan    = 1'b0;
    tablo_dallan_ps = '0;
    if (okuma) begin
      tablo_gecerli = 1'b1;
      tablo_ps      = getir_ps;
    end else if (cekme) begin
      tablo_gecerli   = 1'b1;
      tablo_yaz       = 1'b1;
      tablo_ps        = k_ps[oku_ptr_q];
      tablo_dallan    = k_dallan[oku_ptr_q];
      tablo_dallan_ps = k_hedef[oku_ptr_q];
    end else if (atlama) begin
      tablo_gecerli   = 1'b1;
      tablo_yaz       = 1'b1;
      tablo_ps        = yurut_ps;
      tablo_dallan    = yurut_dallan;
      tablo_dallan_ps = yurut_dallan_ps;
    end
    sonuc_gecerli   = sonuc_gecerli_q;
    sonuc_dallan    = sonuc_gecerli_q ? tablo_sonuc_dallan : 1'b0;
    sonuc_dallan_ps = sonuc_gecerli_q ? tablo_sonuc_dallan_ps : '0;
    kuyruk_sayisi   = sayi_q;
  end

endmodule
